dram_cmd_scheduler: RTL and testbench

In-order DRAM command scheduler between the memory bus and `command_sender`. It accepts one request at a time over a valid/ready handshake and splits the address into bank group, bank, row and column. It tracks the open row of every bank and emits the minimal PRECHARGE / ACTIVATE / READ-WRITE command sequence. Per-bank and data-bus spacing timers keep every command at or beyond the configured DRAM latencies.

---
 rtl/mem_sched_pkg.sv | 29 ++
 rtl/bank_state_table.sv | 59 +++++
 rtl/dram_cmd_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_dram_cmd_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// Shared types for the DRAM command scheduler: command encoding, FSM states and
// the captured-request record.
package mem_sched_pkg;

  typedef enum logic [2:0] {
    CmdRead      = 3'd0,
    CmdWrite     = 3'd1,
    CmdActivate  = 3'd2,
    CmdPrecharge = 3'd3,
    CmdNop       = 3'd7
  } cmd_e;

  typedef enum logic [2:0] {StIdle, StCheck, StPre, StAct, StCol} state_e;

  // Generous field widths so any legal geometry fits; unused upper bits stay zero.
  localparam int unsigned MaxRowBits = 32;
  localparam int unsigned MaxColBits = 16;
  localparam int unsigned MaxIdxBits = 8;

  typedef struct packed {
    logic [MaxRowBits-1:0] row;
    logic [MaxColBits-1:0] col;
    logic [MaxIdxBits-1:0] bg;
    logic [MaxIdxBits-1:0] ba;
    logic                  write;
    logic [7:0][63:0]      data;
  } req_t;

endpackage

// File: rtl/bank_state_table.sv
// Per-bank open flag, open row and saturating countdown timer, read through a
// single lookup index and updated by activate/precharge/load strobes.
module bank_state_table #(
  parameter int unsigned NUM_BANKS  = 8,
  parameter int unsigned ROW_BITS   = 8,
  parameter int unsigned TIMER_BITS = 4,
  localparam int unsigned IdxW      = $clog2(NUM_BANKS)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [IdxW-1:0]       idx_i,
  output logic                  open_o,
  output logic [ROW_BITS-1:0]   row_o,
  output logic                  timer_zero_o,
  input  logic                  act_i,
  input  logic                  pre_i,
  input  logic [ROW_BITS-1:0]   row_i,
  input  logic                  load_i,
  input  logic [TIMER_BITS-1:0] load_val_i
);

  logic [NUM_BANKS-1:0]                 open_q, open_d;
  logic [NUM_BANKS-1:0][ROW_BITS-1:0]   row_q, row_d;
  logic [NUM_BANKS-1:0][TIMER_BITS-1:0] timer_q, timer_d;

  always_comb begin
    open_d  = open_q;
    row_d   = row_q;
    timer_d = timer_q;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (timer_q[i] != '0) timer_d[i] = timer_q[i] - 1'b1;
      if (idx_i == IdxW'(i)) begin
        if (act_i) begin
          open_d[i] = 1'b1;
          row_d[i]  = row_i;
        end
        if (pre_i) open_d[i] = 1'b0;
        if (load_i) timer_d[i] = load_val_i;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      open_q  <= '0;
      row_q   <= '0;
      timer_q <= '0;
    end else begin
      open_q  <= open_d;
      row_q   <= row_d;
      timer_q <= timer_d;
    end
  end

  assign open_o       = open_q[idx_i];
  assign row_o        = row_q[idx_i];
  assign timer_zero_o = (timer_q[idx_i] == '0);

endmodule

// File: rtl/dram_cmd_scheduler.sv
// In-order DRAM command scheduler: one request at a time, open-page policy.
// Optional hit/miss/conflict counters when SCHED_STATS_EN is defined.
module dram_cmd_scheduler
  import mem_sched_pkg::*;
#(
  parameter int unsigned BANK_GROUPS        = 2,
  parameter int unsigned BANKS_PER_GROUP    = 4,
  parameter int unsigned ROW_BITS           = 8,
  parameter int unsigned COL_BITS           = 4,
  parameter int unsigned PADDR_BITS         = 64,
  parameter int unsigned ACTIVATION_LATENCY = 8,
  parameter int unsigned PRECHARGE_LATENCY  = 5,
  parameter int unsigned BURST_CYCLES       = 8,
  localparam int unsigned BgW = $clog2(BANK_GROUPS),
  localparam int unsigned BaW = $clog2(BANKS_PER_GROUP)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  req_write_in,
  input  logic [PADDR_BITS-1:0] req_addr_in,
  input  logic [7:0][63:0]      req_data_in,
  output logic                  cmd_valid_out,
  output logic [2:0]            cmd_out,
  output logic [BgW-1:0]        bank_group_out,
  output logic [BaW-1:0]        bank_out,
  output logic [ROW_BITS-1:0]   row_out,
  output logic [COL_BITS-1:0]   col_out,
  output logic [7:0][63:0]      val_out
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]           stat_hit_out,
  output logic [31:0]           stat_miss_out,
  output logic [31:0]           stat_conflict_out
`endif
);

  localparam int unsigned NumBanks = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int unsigned MaxLat   = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ?
                                     ACTIVATION_LATENCY : PRECHARGE_LATENCY;
  localparam int unsigned TimerW   = $clog2(MaxLat + 1);
  localparam int unsigned BusW     = $clog2(BURST_CYCLES + 1);
  localparam int unsigned RowLsb   = COL_BITS + 2 + BaW + BgW;
  localparam int unsigned AddrTop  = RowLsb + ROW_BITS;

  state_e           state_q, state_d;
  req_t             req_q, req_d;
  logic [BusW-1:0]  bus_q, bus_d;
  logic             bt_open, bt_zero;
  logic [ROW_BITS-1:0] bt_row, req_row;
  logic             issue_pre, issue_act, issue_col, chk_hit, chk_miss, chk_conf;
  logic             cmd_valid_q;
  cmd_e             cmd_q;
  logic [BgW-1:0]   bg_q;
  logic [BaW-1:0]   ba_q;
  logic [ROW_BITS-1:0] row_q;
  logic [COL_BITS-1:0] col_q;

  assign req_row = req_q.row[ROW_BITS-1:0];

  logic unused_bits;
  assign unused_bits = ^{req_addr_in[PADDR_BITS-1:AddrTop], req_addr_in[1:0],
                         req_q.row[MaxRowBits-1:ROW_BITS], req_q.col[MaxColBits-1:COL_BITS],
                         req_q.bg[MaxIdxBits-1:BgW], req_q.ba[MaxIdxBits-1:BaW]};

  bank_state_table #(
    .NUM_BANKS (NumBanks),
    .ROW_BITS  (ROW_BITS),
    .TIMER_BITS(TimerW)
  ) u_banks (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .idx_i       ({req_q.bg[BgW-1:0], req_q.ba[BaW-1:0]}),
    .open_o      (bt_open),
    .row_o       (bt_row),
    .timer_zero_o(bt_zero),
    .act_i       (issue_act),
    .pre_i       (issue_pre),
    .row_i       (req_row),
    .load_i      (issue_act | issue_pre),
    .load_val_i  (issue_pre ? TimerW'(PRECHARGE_LATENCY - 1) :
                              TimerW'(ACTIVATION_LATENCY - 1))
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid_in) state_d = StCheck;
      StCheck: begin
        if (!bt_open)               state_d = StAct;
        else if (bt_row == req_row) state_d = StCol;
        else                        state_d = StPre;
      end
      StPre:   if (bt_zero) state_d = StAct;
      StAct:   if (bt_zero) state_d = StCol;
      StCol:   if (bt_zero && bus_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready_out = 1'b0;
    issue_pre     = 1'b0;
    issue_act     = 1'b0;
    issue_col     = 1'b0;
    chk_hit       = 1'b0;
    chk_miss      = 1'b0;
    chk_conf      = 1'b0;
    unique case (state_q)
      StIdle:  req_ready_out = 1'b1;
      StCheck: begin
        chk_miss = !bt_open;
        chk_hit  = bt_open && (bt_row == req_row);
        chk_conf = bt_open && (bt_row != req_row);
      end
      StPre:   issue_pre = bt_zero;
      StAct:   issue_act = bt_zero;
      StCol:   issue_col = bt_zero && (bus_q == '0);
      default: ;
    endcase
  end

  always_comb begin
    req_d = req_q;
    if (req_valid_in && req_ready_out) begin
      req_d.col   = MaxColBits'(req_addr_in[COL_BITS+1:2]);
      req_d.ba    = MaxIdxBits'(req_addr_in[COL_BITS+2 +: BaW]);
      req_d.bg    = MaxIdxBits'(req_addr_in[COL_BITS+2+BaW +: BgW]);
      req_d.row   = MaxRowBits'(req_addr_in[RowLsb +: ROW_BITS]);
      req_d.write = req_write_in;
      req_d.data  = req_data_in;
    end
    bus_d = issue_col ? BusW'(BURST_CYCLES - 1) : (bus_q != '0 ? bus_q - 1'b1 : bus_q);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      req_q       <= '0;
      bus_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CmdNop;
      bg_q        <= '0;
      ba_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      req_q       <= req_d;
      bus_q       <= bus_d;
      cmd_valid_q <= issue_pre | issue_act | issue_col;
      cmd_q       <= issue_pre ? CmdPrecharge :
                     issue_act ? CmdActivate  :
                     issue_col ? (req_q.write ? CmdWrite : CmdRead) : CmdNop;
      if (issue_pre | issue_act | issue_col) begin
        bg_q <= req_q.bg[BgW-1:0];
        ba_q <= req_q.ba[BaW-1:0];
      end
      if (issue_act) row_q <= req_row;
      if (issue_col) col_q <= req_q.col[COL_BITS-1:0];
    end
  end

  assign cmd_valid_out  = cmd_valid_q;
  assign cmd_out        = cmd_q;
  assign bank_group_out = bg_q;
  assign bank_out       = ba_q;
  assign row_out        = row_q;
  assign col_out        = col_q;
  assign val_out        = req_q.data;

`ifdef SCHED_STATS_EN
  logic [31:0] hit_q, miss_q, conf_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_q  <= '0;
      miss_q <= '0;
      conf_q <= '0;
    end else begin
      if (chk_hit  && hit_q  != '1) hit_q  <= hit_q + 1'b1;
      if (chk_miss && miss_q != '1) miss_q <= miss_q + 1'b1;
      if (chk_conf && conf_q != '1) conf_q <= conf_q + 1'b1;
    end
  end

  assign stat_hit_out      = hit_q;
  assign stat_miss_out     = miss_q;
  assign stat_conflict_out = conf_q;
`else
  logic unused_stats;
  assign unused_stats = ^{chk_hit, chk_miss, chk_conf};
`endif

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed bench for dram_cmd_scheduler: miss, hit, conflict, write data, bus
// spacing and mid-sequence reset, with command edges timed against the handshake.
module tb_dram_cmd_scheduler;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             req_valid_in;
  logic             req_ready_out;
  logic             req_write_in;
  logic [63:0]      req_addr_in;
  logic [7:0][63:0] req_data_in;
  logic             cmd_valid_out;
  logic [2:0]       cmd_out;
  logic [0:0]       bank_group_out;
  logic [1:0]       bank_out;
  logic [7:0]       row_out;
  logic [3:0]       col_out;
  logic [7:0][63:0] val_out;
`ifdef SCHED_STATS_EN
  logic [31:0]      stat_hit_out, stat_miss_out, stat_conflict_out;
`endif

  dram_cmd_scheduler dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .req_valid_in     (req_valid_in),
    .req_ready_out    (req_ready_out),
    .req_write_in     (req_write_in),
    .req_addr_in      (req_addr_in),
    .req_data_in      (req_data_in),
    .cmd_valid_out    (cmd_valid_out),
    .cmd_out          (cmd_out),
    .bank_group_out   (bank_group_out),
    .bank_out         (bank_out),
    .row_out          (row_out),
    .col_out          (col_out),
    .val_out          (val_out)
`ifdef SCHED_STATS_EN
    ,
    .stat_hit_out     (stat_hit_out),
    .stat_miss_out    (stat_miss_out),
    .stat_conflict_out(stat_conflict_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Index of the most recent rising edge; at a falling edge it names the edge
  // whose registered outputs are currently visible.
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present a request after a rising edge; e0 is the index of the handshake edge.
  task automatic send(input logic w, input logic [63:0] a, input logic hold, output int e0);
    @(posedge clk_in); #1;
    req_write_in = w;
    req_addr_in  = a;
    req_valid_in = 1'b1;
    e0 = -100;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_in);
      if (req_ready_out) begin
        e0 = cyc + 1;
        break;
      end
    end
    @(posedge clk_in); #1;
    if (!hold) req_valid_in = 1'b0;
  endtask

  task automatic wait_cmd(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (cmd_valid_out) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    int e0, at, prev_col, seen;
    logic [7:0][63:0] exp_data;

    rst_in       = 1'b1;
    req_valid_in = 1'b0;
    req_write_in = 1'b0;
    req_addr_in  = '0;
    req_data_in  = '0;
    idle(2);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_ready", 512'(req_ready_out), 512'(1));
    chk("rst_valid", 512'(cmd_valid_out), 512'(0));
    chk("rst_cmd", 512'(cmd_out), 512'(7));
    chk("rst_fields", 512'({bank_group_out, bank_out, row_out, col_out}), 512'(0));
    chk("rst_val", 512'(val_out), 512'(0));

    // Read 0x0: bank 0 closed -> ACTIVATE then READ 8 cycles later.
    send(1'b0, 64'h0, 1'b0, e0);
    wait_cmd(at);
    chk("a_act_time", 512'(at), 512'(e0 + 2));
    chk("a_act_cmd", 512'(cmd_out), 512'(2));
    chk("a_act_addr", 512'({bank_group_out, bank_out, row_out}), 512'(0));
    @(negedge clk_in);
    chk("a_pulse", 512'({cmd_valid_out, cmd_out}), 512'({1'b0, 3'd7}));
    chk("a_busy", 512'(req_ready_out), 512'(0));
    wait_cmd(at);
    chk("a_rd_time", 512'(at), 512'(e0 + 10));
    chk("a_rd_cmd", 512'({cmd_out, col_out}), 512'({3'd0, 4'd0}));
    prev_col = at;

    // Read 0x4 straight away: row hit, held off by the data-bus spacing.
    send(1'b0, 64'h4, 1'b0, e0);
    wait_cmd(at);
    chk("b_rd_time", 512'(at), 512'(prev_col + 8));
    chk("b_rd_cmd", 512'({cmd_out, bank_group_out, bank_out, col_out}),
        512'({3'd0, 1'b0, 2'd0, 4'd1}));

    // Read 0x400: bank 0 row 2 while row 0 is open -> conflict.
    idle(10);
    send(1'b0, 64'h400, 1'b0, e0);
    wait_cmd(at);
    chk("c_pre_time", 512'(at), 512'(e0 + 2));
    chk("c_pre_cmd", 512'({cmd_out, bank_group_out, bank_out}), 512'({3'd3, 1'b0, 2'd0}));
    wait_cmd(at);
    chk("c_act_time", 512'(at), 512'(e0 + 7));
    chk("c_act_cmd", 512'({cmd_out, row_out}), 512'({3'd2, 8'd2}));
    wait_cmd(at);
    chk("c_rd_time", 512'(at), 512'(e0 + 15));
    chk("c_rd_cmd", 512'({cmd_out, col_out}), 512'({3'd0, 4'd0}));

    // Write 0x40 to closed bank 1 with valid held high throughout.
    for (int i = 0; i < 8; i++) exp_data[i] = 64'(i);
    req_data_in = exp_data;
    send(1'b1, 64'h40, 1'b1, e0);
    req_data_in = '0;
    wait_cmd(at);
    chk("d_act_time", 512'(at), 512'(e0 + 2));
    chk("d_act_cmd", 512'({cmd_out, bank_group_out, bank_out, row_out}),
        512'({3'd2, 1'b0, 2'd1, 8'd0}));
    chk("d_busy", 512'(req_ready_out), 512'(0));
    wait_cmd(at);
    req_valid_in = 1'b0;
    chk("d_wr_time", 512'(at), 512'(e0 + 10));
    chk("d_wr_cmd", 512'({cmd_out, bank_out, col_out}), 512'({3'd1, 2'd1, 4'd0}));
    chk("d_wr_data", 512'(val_out), 512'(exp_data));
`ifdef SCHED_STATS_EN
    chk("stat_hit", 512'(stat_hit_out), 512'(1));
    chk("stat_miss", 512'(stat_miss_out), 512'(2));
    chk("stat_conf", 512'(stat_conflict_out), 512'(1));
`endif

    // Read 0x44 once bus and bank are idle: hit issues at E0+2.
    idle(10);
    send(1'b0, 64'h44, 1'b0, e0);
    wait_cmd(at);
    chk("e_rd_time", 512'(at), 512'(e0 + 2));
    chk("e_rd_cmd", 512'({cmd_out, bank_out, col_out}), 512'({3'd0, 2'd1, 4'd1}));

    // Read 0x80 (bank 2), reset one cycle after its ACTIVATE.
    idle(10);
    send(1'b0, 64'h80, 1'b0, e0);
    wait_cmd(at);
    chk("f_act_cmd", 512'({cmd_out, bank_out}), 512'({3'd2, 2'd2}));
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_in);
      if (cmd_valid_out) seen++;
    end
    chk("f_no_cmd", 512'(seen), 512'(0));
    chk("f_ready", 512'(req_ready_out), 512'(1));
    chk("f_val_clr", 512'(val_out), 512'(0));
    send(1'b0, 64'h80, 1'b0, e0);
    wait_cmd(at);
    chk("f_react_time", 512'(at), 512'(e0 + 2));
    chk("f_react_cmd", 512'({cmd_out, bank_out, row_out}), 512'({3'd2, 2'd2, 8'd0}));
    wait_cmd(at);
    chk("f_rd_time", 512'(at), 512'(e0 + 10));
    chk("f_rd_cmd", 512'(cmd_out), 512'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
